// File: rtl/press_classifier.sv
// press_classifier
//
// Turns a debounced push-button level into user-interface events:
//   - short_tick  : one-cycle pulse when a single short press has completed
//                   (released, and no second press arrived within the gap)
//   - long_tick   : one-cycle pulse when a press has been held LONG_CYCLES
//   - double_tick : one-cycle pulse when a second press starts within the
//                   release-gap window of a short first press
//   - hold_level  : high for as long as a long press keeps being held
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous, active-low reset
//   btn_level   in   debounced button level, synchronous to clk, 1 = pressed
//   short_tick  out  registered one-cycle pulse
//   long_tick   out  registered one-cycle pulse
//   double_tick out  registered one-cycle pulse
//   hold_level  out  registered level, 1 while in the HOLD state
//   state_dbg   out  current FSM state encoding, for observation only
//
// Handshake: there is no valid/ready pairing on this block. btn_level is
// sampled on every rising clk edge; every output is a plain registered
// signal that is valid in every cycle outside reset.
//
// Parameters: LONG_CYCLES >= 2, DBL_CYCLES >= 2, both < 2**CNT_W.

module press_classifier #(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int DBL_CYCLES  = 12_500_000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_level,
  output logic       short_tick,
  output logic       long_tick,
  output logic       double_tick,
  output logic       hold_level,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ARM    = 3'd0,  // waiting for the button to be released after reset
    IDLE   = 3'd1,  // released, waiting for a first press
    PRESS1 = 3'd2,  // first press in progress, timing towards long press
    HOLD   = 3'd3,  // long press being held
    GAP    = 3'd4,  // released after a short press, timing the gap
    PRESS2 = 3'd5   // second press of a double click, waiting for release
  } state_t;

  // Last count value of each timed window; the window ends when cnt
  // reaches it, so the counter never has to represent the full length.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             short_next;
  logic             long_next;
  logic             double_next;

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ARM;
      cnt         <= '0;
      short_tick  <= 1'b0;
      long_tick   <= 1'b0;
      double_tick <= 1'b0;
      hold_level  <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      short_tick  <= short_next;
      long_tick   <= long_next;
      double_tick <= double_next;
      hold_level  <= (state_next == HOLD);
    end
  end

  // Next-state, counter and tick decode.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    short_next  = 1'b0;
    long_next   = 1'b0;
    double_next = 1'b0;

    case (state)
      ARM: begin
        // A button held through reset must be released before anything
        // can be classified.
        if (!btn_level) state_next = IDLE;
      end

      IDLE: begin
        if (btn_level) state_next = PRESS1;
      end

      PRESS1: begin
        // Release wins over reaching the long-press count in the same cycle.
        if (!btn_level) begin
          state_next = GAP;
        end else if (cnt == LONG_LAST) begin
          state_next = HOLD;
          long_next  = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      HOLD: begin
        if (!btn_level) state_next = IDLE;
      end

      GAP: begin
        // A re-press in the last gap cycle is still a double click.
        if (btn_level) begin
          state_next  = PRESS2;
          double_next = 1'b1;
        end else if (cnt == DBL_LAST) begin
          state_next = IDLE;
          short_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      PRESS2: begin
        // The second press of a double click is never promoted to long.
        if (!btn_level) state_next = IDLE;
      end

      default: begin
        state_next = ARM;
      end
    endcase

    // Every window starts counting from zero.
    if (state_next != state) cnt_next = '0;
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_press_classifier.sv
// Testbench for press_classifier with short timing parameters.
// Directed scenarios pin down exact event cycles; randomized press/release
// runs (with occasional resets) are checked every cycle against a
// timestamp-based behavioural model.

module tb_press_classifier;

  localparam int LONG = 8;
  localparam int DBL  = 4;
  localparam int CW   = 4;

  // ---------------------------------------------------------------- clock/reset
  logic       clk       = 1'b0;
  logic       reset_n   = 1'b0;
  logic       btn_level = 1'b0;
  logic       short_tick;
  logic       long_tick;
  logic       double_tick;
  logic       hold_level;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  press_classifier #(
    .LONG_CYCLES (LONG),
    .DBL_CYCLES  (DBL),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_level   (btn_level),
    .short_tick  (short_tick),
    .long_tick   (long_tick),
    .double_tick (double_tick),
    .hold_level  (hold_level),
    .state_dbg   (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, $signed(act), $signed(exp), cyc - t0);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Tracks the button history as timestamps: when the current first press
  // started, when it was released, and whether a long hold or a second
  // press is ongoing. Events follow directly from elapsed-time arithmetic.
  bit m_wait_release;
  bit m_holding;
  bit m_second;
  int m_press_t;
  int m_rel_t;
  bit exp_s, exp_l, exp_d, exp_h;

  // Event log for the current directed scenario (cycles relative to t0).
  int n_s, n_l, n_d, s_at, l_at, d_at, h_first, h_last;

  task automatic model_reset();
    m_wait_release = 1'b1;
    m_holding      = 1'b0;
    m_second       = 1'b0;
    m_press_t      = -1;
    m_rel_t        = -1;
    exp_s = 1'b0; exp_l = 1'b0; exp_d = 1'b0; exp_h = 1'b0;
  endtask

  task automatic model_step(input logic b, input int n);
    exp_s = 1'b0; exp_l = 1'b0; exp_d = 1'b0;
    if (m_wait_release) begin
      if (!b) m_wait_release = 1'b0;
    end else if (m_holding) begin
      if (!b) m_holding = 1'b0;
    end else if (m_second) begin
      if (!b) m_second = 1'b0;
    end else if (m_press_t >= 0) begin
      if (!b) begin
        m_rel_t   = n;
        m_press_t = -1;
      end else if (n - m_press_t == LONG) begin
        exp_l     = 1'b1;
        m_holding = 1'b1;
        m_press_t = -1;
      end
    end else if (m_rel_t >= 0) begin
      if (b) begin
        exp_d    = 1'b1;
        m_second = 1'b1;
        m_rel_t  = -1;
      end else if (n - m_rel_t == DBL) begin
        exp_s   = 1'b1;
        m_rel_t = -1;
      end
    end else if (b) begin
      m_press_t = n;
    end
    exp_h = m_holding;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (reset_n) model_step(btn_level, cyc);
      cyc++;
    end
  end

  // ---------------------------------------------------------------- compare
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("short_tick",  {31'd0, short_tick},  {31'd0, exp_s});
        check("long_tick",   {31'd0, long_tick},   {31'd0, exp_l});
        check("double_tick", {31'd0, double_tick}, {31'd0, exp_d});
        check("hold_level",  {31'd0, hold_level},  {31'd0, exp_h});
        if (exp_s) begin n_s++; s_at = cyc - t0; end
        if (exp_l) begin n_l++; l_at = cyc - t0; end
        if (exp_d) begin n_d++; d_at = cyc - t0; end
        if (exp_h) begin
          if (h_first < 0) h_first = cyc - t0;
          h_last = cyc - t0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      btn_level = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_test();
    t0 = cyc;
    n_s = 0; n_l = 0; n_d = 0;
    s_at = -1; l_at = -1; d_at = -1;
    h_first = -1; h_last = -1;
  endtask

  task automatic apply_reset(input int n);
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    model_reset();
    begin_test();
    btn_level = 1'b1;
    reset_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset short",  {31'd0, short_tick},  0);
    check("reset long",   {31'd0, long_tick},   0);
    check("reset double", {31'd0, double_tick}, 0);
    check("reset hold",   {31'd0, hold_level},  0);
    reset_n = 1'b1;

    // Button held through reset: nothing may be reported.
    begin_test();
    drive(1'b1, 20);
    drive(1'b0, 2);
    check("armed ticks", n_s + n_l + n_d, 0);
    check("armed hold", h_first, -1);

    // Short press, r = 3.
    begin_test();
    drive(1'b1, 3);
    drive(1'b0, 10);
    check("short at", s_at, 8);
    check("short count", n_s, 1);
    check("short other", n_l + n_d, 0);

    // Long press held cycles 0-19.
    begin_test();
    drive(1'b1, 20);
    drive(1'b0, 6);
    check("long at", l_at, 9);
    check("long count", n_l, 1);
    check("long hold first", h_first, 9);
    check("long hold last", h_last, 20);
    check("long other", n_s + n_d, 0);

    // Release exactly at cycle LONG: still a short press.
    begin_test();
    drive(1'b1, 8);
    drive(1'b0, 8);
    check("late rel long", n_l, 0);
    check("late rel short at", s_at, 13);

    // Double click, re-press at cycle 5, held long.
    begin_test();
    drive(1'b1, 3);
    drive(1'b0, 2);
    drive(1'b1, 20);
    drive(1'b0, 5);
    check("dbl at", d_at, 6);
    check("dbl count", n_d, 1);
    check("dbl other", n_s + n_l, 0);

    // Re-press in the last gap cycle.
    begin_test();
    drive(1'b1, 3);
    drive(1'b0, 4);
    drive(1'b1, 3);
    drive(1'b0, 6);
    check("dbl edge at", d_at, 8);
    check("dbl edge short", n_s, 0);

    // Reset during HOLD, button still pressed afterwards.
    begin_test();
    drive(1'b1, 12);
    check("pre-reset hold", {31'd0, hold_level}, 1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async hold clear", {31'd0, hold_level}, 0);
    check("async long clear", {31'd0, long_tick}, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    begin_test();
    drive(1'b1, 5);
    drive(1'b0, 3);
    check("post-reset ticks", n_s + n_l + n_d, 0);
    check("post-reset hold", h_first, -1);
    begin_test();
    drive(1'b1, 2);
    drive(1'b0, 8);
    check("post-reset short at", s_at, 7);

    // Randomized press/release runs with occasional resets.
    for (int seg = 0; seg < 200; seg++) begin
      if ($urandom_range(0, 49) == 0) apply_reset($urandom_range(1, 3));
      drive(1'b1, $urandom_range(1, 12));
      drive(1'b0, $urandom_range(1, 7));
    end
    drive(1'b0, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
